// File: rtl/mem_arbiter.sv
// Two-way arbiter sharing one memory port between fetch (imem) and data (dmem) requesters.
// Fixed dmem priority by default; define MEM_ARBITER_RR_EN for round-robin on simultaneous requests.
module mem_arbiter #(
  parameter int XLEN = 32,
  parameter int STRB = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            imem_valid,
  input  logic            imem_instr,
  input  logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_wdata,
  input  logic [STRB-1:0] imem_wstrb,
  output logic [XLEN-1:0] imem_rdata,
  output logic            imem_ready,
  input  logic            dmem_valid,
  input  logic            dmem_instr,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  input  logic [STRB-1:0] dmem_wstrb,
  output logic [XLEN-1:0] dmem_rdata,
  output logic            dmem_ready,
  output logic            mem_valid,
  output logic            mem_instr,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [STRB-1:0] mem_wstrb,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [1:0]      gnt
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t state;
  logic   last_d;
  logic   both_pick_d;

`ifdef MEM_ARBITER_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  // On a tie, round-robin favours the side that was not served last.
  assign both_pick_d = RR_EN ? ~last_d : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dmem_valid && (!imem_valid || both_pick_d))
            state <= GNT_D;
          else if (imem_valid)
            state <= GNT_I;
        end
        GNT_I: begin
          if (mem_ready) begin
            state  <= IDLE;
            last_d <= 1'b0;
          end else if (!imem_valid) begin
            state <= IDLE;
          end
        end
        GNT_D: begin
          if (mem_ready) begin
            state  <= IDLE;
            last_d <= 1'b1;
          end else if (!dmem_valid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_valid  = 1'b0;
    mem_instr  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    case (state)
      GNT_I: begin
        mem_valid  = imem_valid;
        mem_instr  = imem_instr;
        mem_addr   = imem_addr;
        mem_wdata  = imem_wdata;
        mem_wstrb  = imem_wstrb;
        imem_ready = mem_ready;
      end
      GNT_D: begin
        mem_valid  = dmem_valid;
        mem_instr  = dmem_instr;
        mem_addr   = dmem_addr;
        mem_wdata  = dmem_wdata;
        mem_wstrb  = dmem_wstrb;
        dmem_ready = mem_ready;
      end
      default: ;
    endcase
  end

  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;
  assign gnt        = {state == GNT_D, state == GNT_I};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a randomized run
// checked every cycle against an ownership-level reference model.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_valid, imem_instr, imem_ready;
  logic [31:0] imem_addr, imem_wdata, imem_rdata;
  logic [3:0]  imem_wstrb;
  logic        dmem_valid, dmem_instr, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  gnt;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .imem_valid(imem_valid), .imem_instr(imem_instr), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_wstrb(imem_wstrb), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready),
    .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .gnt(gnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [137:0] act, input logic [137:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: who owns the port (0 none, 1 fetch, 2 data) and who was served last.
  int owner = 0;
  bit served_d = 1'b0;
  bit model_ok = 1'b0;
  bit i_rdy_seen = 1'b0;
  bit d_rdy_seen = 1'b0;

  always @(negedge clk) begin
    logic [137:0] exp_v, act_v;
    logic        e_valid, e_instr, e_irdy, e_drdy;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic [1:0]  e_gnt;
    if (model_ok) begin
      e_valid = 0; e_instr = 0; e_addr = 0; e_wdata = 0; e_wstrb = 0;
      e_irdy = 0; e_drdy = 0; e_gnt = 2'b00;
      if (owner == 1) begin
        e_valid = imem_valid; e_instr = imem_instr; e_addr = imem_addr;
        e_wdata = imem_wdata; e_wstrb = imem_wstrb; e_irdy = mem_ready; e_gnt = 2'b01;
      end else if (owner == 2) begin
        e_valid = dmem_valid; e_instr = dmem_instr; e_addr = dmem_addr;
        e_wdata = dmem_wdata; e_wstrb = dmem_wstrb; e_drdy = mem_ready; e_gnt = 2'b10;
      end
      exp_v = {e_valid, e_instr, e_addr, e_wdata, e_wstrb, e_irdy, e_drdy, mem_rdata, mem_rdata, e_gnt};
      act_v = {mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, imem_ready, dmem_ready,
               imem_rdata, dmem_rdata, gnt};
      chk("cycle_model", act_v, exp_v);
    end
    i_rdy_seen = imem_ready;
    d_rdy_seen = dmem_ready;
    if (rst) begin
      owner = 0; served_d = 0; model_ok = 1;
    end else if (model_ok) begin
      if (owner == 0) begin
        if (imem_valid && dmem_valid) begin
`ifdef MEM_ARBITER_RR_EN
          owner = served_d ? 1 : 2;
`else
          owner = 2;
`endif
        end else if (dmem_valid) owner = 2;
        else if (imem_valid) owner = 1;
      end else if (mem_ready) begin
        served_d = (owner == 2);
        owner = 0;
      end else if ((owner == 1 && !imem_valid) || (owner == 2 && !dmem_valid)) begin
        owner = 0;
      end
    end
  end

  initial begin
    logic [1:0] g [4];
    int n;
    rst = 1; imem_valid = 1; imem_instr = 1; imem_addr = 32'h100; imem_wdata = 0; imem_wstrb = 0;
    dmem_valid = 0; dmem_instr = 0; dmem_addr = 0; dmem_wdata = 0; dmem_wstrb = 0;
    mem_ready = 0; mem_rdata = 0;

    // Reset held two cycles with a fetch pending
    tick(); tick();
    @(negedge clk);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_imem_ready", imem_ready, 0);
    tick(); rst = 0;
    tick();
    @(negedge clk);
    chk("fetch_gnt", gnt, 2'b01);
    chk("fetch_addr", mem_addr, 32'h100);
    chk("fetch_wstrb", mem_wstrb, 0);
    chk("fetch_valid", mem_valid, 1);
    tick();
    @(negedge clk);
    chk("fetch_wait_rdy", imem_ready, 0);
    tick(); mem_ready = 1; mem_rdata = 32'h13;
    @(negedge clk);
    chk("fetch_rdy", imem_ready, 1);
    chk("fetch_rdata", imem_rdata, 32'h13);
    chk("fetch_drdy", dmem_ready, 0);
    tick(); mem_ready = 0; imem_valid = 0;
    @(negedge clk);
    chk("fetch_idle_gnt", gnt, 0);

    // Simultaneous fetch and store
    tick();
    imem_valid = 1; imem_addr = 32'h200;
    dmem_valid = 1; dmem_addr = 32'h1000; dmem_wdata = 32'hDEADBEEF; dmem_wstrb = 4'hF;
    tick(); mem_ready = 1;
    @(negedge clk);
    chk("both_gnt_d", gnt, 2'b10);
    chk("both_wstrb", mem_wstrb, 4'hF);
    chk("both_wdata", mem_wdata, 32'hDEADBEEF);
    chk("both_addr", mem_addr, 32'h1000);
    chk("both_drdy", dmem_ready, 1);
    chk("both_irdy", imem_ready, 0);
    tick(); mem_ready = 0; dmem_valid = 0; dmem_wstrb = 0;
    @(negedge clk);
    chk("both_idle", gnt, 0);
    tick();
    @(negedge clk);
    chk("both_then_i", gnt, 2'b01);
    chk("both_i_addr", mem_addr, 32'h200);

    // No preemption while the fetch stalls
    tick(); dmem_valid = 1; dmem_addr = 32'h2000; dmem_wdata = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("nopre_gnt", gnt, 2'b01);
      tick();
    end
    mem_ready = 1;
    @(negedge clk);
    chk("nopre_irdy", imem_ready, 1);
    tick(); mem_ready = 0; imem_valid = 0;
    @(negedge clk);
    chk("nopre_idle", gnt, 0);
    tick();
    @(negedge clk);
    chk("nopre_then_d", gnt, 2'b10);
    chk("nopre_d_addr", mem_addr, 32'h2000);

    // Requester abandons its request
    tick(); dmem_valid = 0;
    @(negedge clk);
    chk("abort_valid", mem_valid, 0);
    chk("abort_gnt_same", gnt, 2'b10);
    tick();
    @(negedge clk);
    chk("abort_gnt_next", gnt, 0);

    // Reset in the middle of a data grant
    tick(); dmem_valid = 1;
    tick();
    @(negedge clk);
    chk("rstmid_gnt", gnt, 2'b10);
    tick(); rst = 1;
    @(negedge clk);
    chk("rstmid_drdy", dmem_ready, 0);
    tick(); rst = 0; dmem_valid = 0;
    @(negedge clk);
    chk("rstmid_gnt0", gnt, 0);
    chk("rstmid_valid0", mem_valid, 0);
    chk("rstmid_drdy0", dmem_ready, 0);

    // Both sides requesting continuously
    tick(); imem_valid = 1; dmem_valid = 1; mem_ready = 1;
    n = 0;
    for (int k = 0; k < 20 && n < 4; k++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin g[n] = gnt; n++; end
      tick();
    end
    chk("arb_count", n, 4);
    for (int k = 0; k < n; k++) begin
`ifdef MEM_ARBITER_RR_EN
      chk("arb_seq", g[k], (k % 2 == 0) ? 2'b10 : 2'b01);
`else
      chk("arb_seq", g[k], 2'b10);
`endif
    end
    imem_valid = 0; dmem_valid = 0; mem_ready = 0;

    // Randomized traffic with occasional protocol violations and resets
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (imem_valid && i_rdy_seen) imem_valid = 0;
      else if (!imem_valid && $urandom_range(2) == 0) begin
        imem_valid = 1; imem_instr = 1; imem_addr = $urandom & 32'hFFFF_FFFC;
        imem_wdata = 0; imem_wstrb = 0;
      end else if (imem_valid && $urandom_range(49) == 0) imem_valid = 0;
      if (dmem_valid && d_rdy_seen) dmem_valid = 0;
      else if (!dmem_valid && $urandom_range(2) == 0) begin
        dmem_valid = 1; dmem_instr = $urandom_range(1) == 1; dmem_addr = $urandom;
        dmem_wdata = $urandom; dmem_wstrb = ($urandom_range(1) == 1) ? 4'($urandom) : 4'h0;
      end else if (dmem_valid && $urandom_range(49) == 0) dmem_valid = 0;
      mem_ready = ($urandom_range(2) == 0);
      mem_rdata = $urandom;
      rst = ($urandom_range(199) == 0);
    end
    tick();
    rst = 0; imem_valid = 0; dmem_valid = 0; mem_ready = 0;
    tick();
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
